// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - PC-hold/bubble sequencing for load-use, jump flush and halt drain
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       dec_rr1,
    input  logic [4:0]       dec_rr2,
    input  logic             dec_uses_rs1,
    input  logic             dec_uses_rs2,
    input  logic             dec_halt,
    input  logic [4:0]       ex_write_reg,
    input  logic             ex_reg_wrenable,
    input  logic             ex_mem_to_reg,
    input  logic             ex_should_jump,
    output logic             pc_hold,
    output logic             bubble,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        STALL  = 2'b01,
        DRAIN  = 2'b10,
        HALTED = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] drain_q, drain_d;
    logic       halted_q;
    logic       stall_inc, flush_inc;
    logic       lu;

    assign lu = ex_mem_to_reg && ex_reg_wrenable && (ex_write_reg != 5'd0) &&
                ((dec_uses_rs1 && (dec_rr1 == ex_write_reg)) ||
                 (dec_uses_rs2 && (dec_rr2 == ex_write_reg)));

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        pc_hold   = 1'b0;
        bubble    = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state_q)
            RUN, STALL: begin
                if (ex_should_jump) begin
                    bubble    = 1'b1;
                    flush_inc = 1'b1;
                    state_d   = RUN;
                end else if (lu) begin
                    pc_hold   = 1'b1;
                    bubble    = 1'b1;
                    stall_inc = 1'b1;
                    state_d   = STALL;
                end else if (dec_halt) begin
                    pc_hold   = 1'b1;
                    state_d   = DRAIN;
                    drain_d   = 4'(DRAIN_CYCLES);
                end else begin
                    state_d   = RUN;
                end
            end
            DRAIN: begin
                pc_hold = 1'b1;
                bubble  = 1'b1;
                drain_d = (drain_q != 4'd0) ? drain_q - 4'd1 : 4'd0;
                if (drain_q <= 4'd1) begin
                    state_d = HALTED;
                end
            end
            default: begin
                pc_hold = 1'b1;
                bubble  = 1'b1;
            end
        endcase
        // Fetch is frozen for the whole time reset is held, independent of the clock.
        if (!rst_n) begin
            pc_hold = 1'b1;
            bubble  = 1'b1;
        end
    end

    // halted trails the HALTED state by one edge: it rises DRAIN_CYCLES+1 edges after the halt is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            drain_q   <= 4'd0;
            halted_q  <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            halted_q <= (state_q == HALTED);
            if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_inc && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign state  = state_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  dec_rr1 = '0, dec_rr2 = '0, ex_write_reg = '0;
    logic        dec_uses_rs1 = 1'b0, dec_uses_rs2 = 1'b0, dec_halt = 1'b0;
    logic        ex_reg_wrenable = 1'b0, ex_mem_to_reg = 1'b0, ex_should_jump = 1'b0;
    logic        pc_hold, bubble, halted;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_pc_hold, s_bubble, s_halted;
    logic [1:0]  s_state;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic        hold;
        logic        bub;
        logic [1:0]  st;
        logic        hlt;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_rr1(dec_rr1), .dec_rr2(dec_rr2),
        .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
        .dec_halt(dec_halt), .ex_write_reg(ex_write_reg),
        .ex_reg_wrenable(ex_reg_wrenable), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_should_jump(ex_should_jump),
        .pc_hold(pc_hold), .bubble(bubble), .halted(halted), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(1), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .dec_rr1(dec_rr1), .dec_rr2(dec_rr2),
        .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
        .dec_halt(dec_halt), .ex_write_reg(ex_write_reg),
        .ex_reg_wrenable(ex_reg_wrenable), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_should_jump(ex_should_jump),
        .pc_hold(s_pc_hold), .bubble(s_bubble), .halted(s_halted), .state(s_state),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(logic [4:0] r1, logic [4:0] r2, logic u1, logic u2, logic dh,
                         logic [4:0] wr, logic we, logic mr, logic j);
        dec_rr1 = r1; dec_rr2 = r2; dec_uses_rs1 = u1; dec_uses_rs2 = u2; dec_halt = dh;
        ex_write_reg = wr; ex_reg_wrenable = we; ex_mem_to_reg = mr; ex_should_jump = j;
    endtask

    task automatic step(string tag, logic eh, logic eb, logic [1:0] es, logic ehd,
                        logic [15:0] esc, logic [15:0] efc);
        exp_t e;
        sb.push_back('{tag, eh, eb, es, ehd, esc, efc});
        @(negedge clk);
        e = sb.pop_front();
        check({e.tag, "_pc_hold"}, 16'(pc_hold), 16'(e.hold));
        check({e.tag, "_bubble"}, 16'(bubble), 16'(e.bub));
        @(posedge clk);
        #1;
        check({e.tag, "_state"}, 16'(state), 16'(e.st));
        check({e.tag, "_halted"}, 16'(halted), 16'(e.hlt));
        check({e.tag, "_stall_cnt"}, stall_cnt, e.sc);
        check({e.tag, "_flush_cnt"}, flush_cnt, e.fc);
    endtask

    task automatic check_reset(string tag);
        check({tag, "_pc_hold"}, 16'(pc_hold), 16'd1);
        check({tag, "_bubble"}, 16'(bubble), 16'd1);
        check({tag, "_state"}, 16'(state), 16'd0);
        check({tag, "_halted"}, 16'(halted), 16'd0);
        check({tag, "_stall_cnt"}, stall_cnt, 16'd0);
        check({tag, "_flush_cnt"}, flush_cnt, 16'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check_reset("rst0");
        release_reset();

        //          r1 r2 u1 u2 dh wr we mr j
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("idle",       0, 0, 2'b00, 0, 0, 0);
        drive(0, 5, 0, 1, 0, 5, 1, 1, 0); step("lu_rs2",     1, 1, 2'b01, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("stall_end",  0, 0, 2'b00, 0, 1, 0);
        drive(0, 0, 0, 1, 0, 0, 1, 1, 0); step("x0_no_lu",   0, 0, 2'b00, 0, 1, 0);
        drive(0, 5, 0, 0, 0, 5, 1, 1, 0); step("unused_rs2", 0, 0, 2'b00, 0, 1, 0);
        drive(7, 0, 1, 0, 0, 7, 1, 1, 0); step("lu_rs1",     1, 1, 2'b01, 0, 2, 0);
        drive(7, 0, 1, 0, 0, 7, 1, 1, 0); step("restall",    1, 1, 2'b01, 0, 3, 0);
        drive(7, 0, 1, 0, 0, 7, 1, 1, 1); step("jmp_stall",  0, 1, 2'b00, 0, 3, 1);
        drive(7, 0, 1, 0, 0, 7, 1, 1, 1); step("jmp_lu",     0, 1, 2'b00, 0, 3, 2);
        drive(7, 0, 1, 0, 0, 7, 1, 0, 0); step("not_load",   0, 0, 2'b00, 0, 3, 2);
        drive(7, 0, 1, 0, 1, 7, 1, 1, 0); step("lu_over_hl", 1, 1, 2'b01, 0, 4, 2);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0); step("halt_acc",   1, 0, 2'b10, 0, 4, 2);
        drive(7, 7, 1, 1, 1, 7, 1, 1, 1); step("drain1",     1, 1, 2'b10, 0, 4, 2);
        drive(7, 7, 1, 1, 1, 7, 1, 1, 1); step("drain2",     1, 1, 2'b10, 0, 4, 2);
        drive(7, 7, 1, 1, 1, 7, 1, 1, 1); step("drain3",     1, 1, 2'b11, 0, 4, 2);
        drive(7, 7, 1, 1, 1, 7, 1, 1, 1); step("halted",     1, 1, 2'b11, 1, 4, 2);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1); step("halt_jmp",   1, 1, 2'b11, 1, 4, 2);

        #2;
        rst_n = 1'b0;
        #1;
        check_reset("rst_halted");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        release_reset();

        drive(0, 0, 0, 0, 0, 0, 0, 0, 1); step("jmp2",       0, 1, 2'b00, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0); step("halt_acc2",  1, 0, 2'b10, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("drain_a",    1, 1, 2'b10, 0, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("rst_drain");
        release_reset();
        step("resume", 0, 0, 2'b00, 0, 0, 0);

        for (int i = 1; i <= 17; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
            step("sat_jmp", 0, 1, 2'b00, 0, 0, 16'(i));
            check("sat_flush4", 16'(s_flush_cnt), (i > 15) ? 16'd15 : 16'(i));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
